// File: rtl/uart_burst_loopback.sv
// -----------------------------------------------------------------------------
// uart_burst_loopback
//
// Sends a burst of BURST_LEN test words through an external UART transmitter.
// Each word goes out only after the looped-back copy of the previous word has
// arrived. Received words are buffered in a first-word-fall-through FIFO and
// presented on a valid/ready output stream. If a word does not come back
// within TIMEOUT_CYC cycles, the burst is abandoned. A word that arrives while
// the FIFO is full is dropped.
//
// Optional feature (compile-time macro UART_LOOPBACK_CHECK_EN):
//   When defined, each received word is compared against the word that was
//   sent, and mismatches are counted in err_cnt, which saturates at 0xFFFF.
//   When undefined, the compare logic is absent and err_cnt is tied to 0.
//
// Ports:
//   sys_clk, sys_rst_n   clock; asynchronous active-low reset
//   start                one-cycle burst request (accepted only when idle)
//   pattern_sel          0 = incrementing words, 1 = alternating 0x55../0xAA..
//   tx_busy              UART transmitter busy
//   tx_en, tx_data       one-cycle transmit strobe and the word to send
//   rx_done, rx_data     UART receiver word-complete strobe and the word
//   m_valid, m_data      output stream (FIFO head), popped when m_ready = 1
//   m_ready              output stream ready
//   busy                 burst in progress
//   done                 one-cycle burst-complete pulse
//   timeout, overflow    sticky status flags for the last burst
//   fifo_level           current FIFO occupancy
//   err_cnt              compare mismatch count
// -----------------------------------------------------------------------------
module uart_burst_loopback #(
  parameter int DATA_W      = 8,
  parameter int BURST_LEN   = 256,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 8680
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          start,
  input  logic                          pattern_sel,
  input  logic                          tx_busy,
  output logic                          tx_en,
  output logic [DATA_W-1:0]             tx_data,
  input  logic                          rx_done,
  input  logic [DATA_W-1:0]             rx_data,
  output logic                          m_valid,
  output logic [DATA_W-1:0]             m_data,
  input  logic                          m_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          timeout,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   err_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [15:0]       LAST_WORD = 16'(BURST_LEN - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);
  // 0x5555_5555 truncated to DATA_W gives 0x55.. with bit 0 set.
  localparam logic [DATA_W-1:0] ALT_WORD  = DATA_W'(32'h5555_5555);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_RX,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  logic [15:0]       word_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              pat_alt;

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              accept;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;

  // Words are only taken while a reply is awaited; strobes elsewhere are noise.
  assign accept = (state == S_WAIT_RX) && rx_done;
  assign full   = (fifo_level == LVL_FULL);
  assign pop    = m_valid && m_ready;
  // At full, a simultaneous pop frees the slot this push is about to use.
  assign push   = accept && (!full || pop);
  assign drop   = accept && full && !pop;

  assign m_valid = (fifo_level != '0);
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

  // NOTE: the storage array has no reset; m_data is gated by m_valid, so stale
  // contents are never visible, and leaving it unreset lets it map to RAM.
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      // Pointers wrap naturally because FIFO_DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Burst control FSM (all outputs registered)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block samples the pre-edge values of the others.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= S_IDLE;
      tx_en    <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
      overflow <= 1'b0;
      word_cnt <= '0;
      tmo_cnt  <= '0;
      pat_alt  <= 1'b0;
    end else begin
      tx_en <= 1'b0;
      done  <= 1'b0;
      if (drop) overflow <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start) begin
            word_cnt <= '0;
            timeout  <= 1'b0;
            overflow <= 1'b0;
            pat_alt  <= pattern_sel;
            tx_data  <= pattern_sel ? ALT_WORD : '0;
            busy     <= 1'b1;
            state    <= S_SEND;
          end
        end

        S_SEND: begin
          if (!tx_busy) begin
            tx_en   <= 1'b1;
            tmo_cnt <= '0;
            state   <= S_WAIT_RX;
          end
        end

        S_WAIT_RX: begin
          if (rx_done) begin
            word_cnt <= word_cnt + 16'd1;
            if (word_cnt == LAST_WORD) begin
              state <= S_DRAIN;
            end else begin
              tx_data <= pat_alt ? ~tx_data : tx_data + DATA_W'(1);
              state   <= S_SEND;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            timeout <= 1'b1;
            state   <= S_DRAIN;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        // Wait for the consumer to empty the FIFO; level is registered, so
        // the move to DONE lands one cycle after the last pop.
        S_DRAIN: begin
          if (fifo_level == '0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional loopback data check
  // ---------------------------------------------------------------------------
`ifdef UART_LOOPBACK_CHECK_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      err_cnt <= '0;
    end else if (accept && (rx_data != tx_data) && (err_cnt != 16'hFFFF)) begin
      // tx_data still holds the word that produced this reply.
      err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: doc/uart_burst_loopback.md
UART_BURST_LOOPBACK -- requirements
Module: uart_burst_loopback

Interface
REQ-001 SHALL have parameter DATA_W, default 8, UART word width in bits (5..16).
REQ-002 SHALL have parameter BURST_LEN, default 256, words per burst (1..65535).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, receive buffer depth (power of 2, 2..1024); independent of BURST_LEN.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 8680, maximum sys_clk cycles allowed from tx_en to rx_done.
REQ-005 SHALL have ports (clock and reset first):
  sys_clk  in  1  clock
  sys_rst_n  in  1  reset, asynchronous, active-low
  start  in  1  one-cycle burst request
  pattern_sel  in  1  0 = incrementing, 1 = alternating 0x55../0xAA..
  tx_busy  in  1  UART transmitter busy
  tx_en  out  1  one-cycle transmit strobe
  tx_data  out  DATA_W  word to transmit
  rx_done  in  1  UART receiver word-complete strobe
  rx_data  in  DATA_W  received word, valid with rx_done
  m_valid  out  1  output stream valid
  m_data  out  DATA_W  output stream data
  m_ready  in  1  output stream ready
  busy  out  1  burst in progress
  done  out  1  one-cycle burst-complete pulse
  timeout  out  1  sticky: receive timeout occurred in last burst
  overflow  out  1  sticky: received word dropped, FIFO full
  fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
  err_cnt  out  16  compare mismatch count

Function
REQ-006 SHALL implement states IDLE, SEND, WAIT_RX, DRAIN, DONE; busy = 1 in every state except IDLE.
REQ-007 IDLE: start = 1 SHALL clear word counter, timeout, overflow, err_cnt, latch pattern_sel, load first word (0 for incrementing, 0x55.. for alternating), go SEND; start in any other state SHALL be ignored.
REQ-008 SEND: when tx_busy = 0, SHALL assert tx_en for exactly one cycle with tx_data = current word and go WAIT_RX; tx_data SHALL hold until the next word is loaded.
REQ-009 WAIT_RX: rx_done = 1 SHALL push rx_data into FIFO (fifo_level increments the following cycle) and increment word counter; if counter reaches BURST_LEN go DRAIN, else advance pattern (increment mod 2^DATA_W, or bitwise invert) and go SEND.
REQ-010 WAIT_RX: timeout counter SHALL restart on entry; if TIMEOUT_CYC cycles elapse without rx_done, SHALL set timeout and go DRAIN without sending further words.
REQ-011 rx_done outside WAIT_RX SHALL be ignored (no push, no count).
REQ-012 m_valid SHALL equal FIFO not-empty in all states; a pop SHALL occur on m_valid & m_ready; m_data SHALL be the FIFO head, first-word fall-through, in receive order.
REQ-013 Push while FIFO full and no simultaneous pop SHALL drop the word and set overflow; push and pop in the same cycle at full SHALL both succeed, level unchanged.
REQ-014 Simultaneous push and pop at any level SHALL leave fifo_level unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-015 DRAIN: SHALL go DONE in the cycle after FIFO becomes empty.
REQ-016 DONE: SHALL assert done for one cycle and return to IDLE; timeout, overflow, err_cnt SHALL hold until next start.

Reset
REQ-017 sys_rst_n low SHALL asynchronously force IDLE, empty FIFO, and all outputs to 0 (tx_en, tx_data, m_valid, busy, done, timeout, overflow, fifo_level, err_cnt); m_data SHALL be 0 while m_valid = 0.
REQ-018 Reset mid-burst SHALL discard all FIFO contents and counters; no done pulse SHALL be produced.

Configuration
REQ-019 With macro UART_LOOPBACK_CHECK_EN defined, each accepted rx_done in WAIT_RX SHALL compare rx_data to tx_data and increment err_cnt on mismatch, saturating at 0xFFFF.
REQ-020 Without UART_LOOPBACK_CHECK_EN, compare logic SHALL be absent and err_cnt SHALL be constant 0.

Verification
REQ-021 DATA_W=8, BURST_LEN=256, tx looped to rx via UART models at 115200/50 MHz, m_ready=1, start -> m_data 0x00..0xFF in order, done once, err_cnt=0, timeout=0, overflow=0.
REQ-022 pattern_sel=1, BURST_LEN=4 -> tx_data 0x55, 0xAA, 0x55, 0xAA; same four words on m_data.
REQ-023 FIFO_DEPTH=4, BURST_LEN=8, m_ready=0 throughout burst -> fifo_level stops at 4, overflow=1, after m_ready=1 exactly words 0x00..0x03 drain, then done.
REQ-024 rx_done never asserted -> timeout=1 after TIMEOUT_CYC cycles, only one tx_en, done pulse, busy=0.
REQ-025 UART_LOOPBACK_CHECK_EN defined, bench flips bit 0 of words 3 and 7 of 16 -> err_cnt=2; macro undefined -> err_cnt=0.
REQ-026 sys_rst_n low at word 100 of 256 -> all outputs 0 next edge, fifo_level=0, no done; new start runs full clean burst.
